// File: rtl/vector_issue_sequencer_if.sv
// Handshake and beat-control bundle between the vector decoder and the issue sequencer.
// The master side is the decoder; the slave side is the sequencer.
interface vector_issue_sequencer_if;
  logic       req;
  logic       gnt;
  logic [4:0] vl;
  logic [1:0] vsew;
  logic       write_en;
  logic       stall;
  logic [1:0] cycle_count;
  logic [1:0] elements_to_write;
  logic       vec_reg_write;
  logic       busy;
  logic       rvalid;

  modport master (
    output req, vl, vsew, write_en, stall,
    input  gnt, cycle_count, elements_to_write, vec_reg_write, busy, rvalid
  );

  modport slave (
    input  req, vl, vsew, write_en, stall,
    output gnt, cycle_count, elements_to_write, vec_reg_write, busy, rvalid
  );
endinterface

// File: rtl/vector_issue_sequencer.sv
// Splits an accepted vector op into beats of up to four elements, drains the
// downstream pipe for PIPE_DEPTH cycles, then pulses rvalid for one cycle.
module vector_issue_sequencer #(
  parameter int PIPE_DEPTH = 1
) (
  input logic                      clk,
  input logic                      reset,
  vector_issue_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;

  localparam logic [1:0] DRAIN_LOAD = (PIPE_DEPTH > 0) ? 2'(PIPE_DEPTH - 1) : 2'd0;

  // Element-width code 3 is reserved and yields an empty op.
  function automatic logic [4:0] eff_vl_f(input logic [4:0] v, input logic [1:0] sew);
    logic [4:0] vmax;
    case (sew)
      2'd0:    vmax = 5'd16;
      2'd1:    vmax = 5'd8;
      2'd2:    vmax = 5'd4;
      default: vmax = 5'd0;
    endcase
    return (v < vmax) ? v : vmax;
  endfunction

  state_t     state_q, state_n;
  logic [4:0] vl_q;
  logic [1:0] vsew_q;
  logic       write_en_q;
  logic [1:0] beat_q;
  logic [1:0] drain_q;

  logic       accept;
  logic [4:0] eff_vl;
  logic [2:0] last_beat;
  logic [4:0] final_elems;
  logic       is_last;
  logic       retire;

  assign accept      = bus.req && (state_q == IDLE);
  assign eff_vl      = eff_vl_f(vl_q, vsew_q);
  assign last_beat   = 3'((eff_vl + 5'd3) >> 2) - 3'd1;
  assign final_elems = eff_vl - {last_beat, 2'b00};
  assign is_last     = ({1'b0, beat_q} == last_beat);
  assign retire      = (state_q == RUN) && !bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vl_q       <= '0;
      vsew_q     <= '0;
      write_en_q <= 1'b0;
      beat_q     <= '0;
      drain_q    <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        vl_q       <= bus.vl;
        vsew_q     <= bus.vsew;
        write_en_q <= bus.write_en;
        beat_q     <= '0;
      end else if (retire && !is_last) begin
        beat_q <= beat_q + 2'd1;
      end
      if (retire && is_last) begin
        drain_q <= DRAIN_LOAD;
      end else if (state_q == DRAIN && drain_q != 2'd0) begin
        drain_q <= drain_q - 2'd1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n = (eff_vl_f(bus.vl, bus.vsew) == 5'd0) ? RESP : RUN;
        end
      end
      RUN: begin
        if (retire && is_last) begin
          state_n = (PIPE_DEPTH > 0) ? DRAIN : RESP;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) begin
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt               = (state_q == IDLE);
    bus.busy              = (state_q != IDLE);
    bus.rvalid            = (state_q == RESP);
    bus.cycle_count       = 2'd0;
    bus.elements_to_write = 2'd0;
    bus.vec_reg_write     = 1'b0;
    if (state_q == RUN) begin
      bus.cycle_count       = beat_q;
      bus.elements_to_write = is_last ? 2'(final_elems - 5'd1) : 2'd3;
      bus.vec_reg_write     = write_en_q && !bus.stall;
    end
  end

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed bench for vector_issue_sequencer with PIPE_DEPTH=1.
module tb_vector_issue_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  vector_issue_sequencer_if bus();

  vector_issue_sequencer #(.PIPE_DEPTH(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks every output: gnt, busy, rvalid, cycle_count, elements_to_write, vec_reg_write.
  task automatic outs(input string tag, input logic g, input logic b, input logic r,
                      input logic [1:0] cc, input logic [1:0] etw, input logic vrw);
    chk({tag, ".gnt"},    {7'd0, bus.gnt},           {7'd0, g});
    chk({tag, ".busy"},   {7'd0, bus.busy},          {7'd0, b});
    chk({tag, ".rvalid"}, {7'd0, bus.rvalid},        {7'd0, r});
    chk({tag, ".cc"},     {6'd0, bus.cycle_count},   {6'd0, cc});
    chk({tag, ".etw"},    {6'd0, bus.elements_to_write}, {6'd0, etw});
    chk({tag, ".vrw"},    {7'd0, bus.vec_reg_write}, {7'd0, vrw});
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] v, input logic [1:0] sew, input logic we);
    bus.req = 1'b1; bus.vl = v; bus.vsew = sew; bus.write_en = we;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 1'b0; bus.vl = '0; bus.vsew = '0; bus.write_en = 1'b0; bus.stall = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1 outs("reset", 1, 0, 0, 0, 0, 0);

    // vl=10, sew=8b: beats of 4,4,2 then one drain cycle
    cyc(); issue(5'd10, 2'd0, 1'b1); #1 chk("s1.gnt_T", {7'd0, bus.gnt}, 8'd1);
    cyc(); bus.req = 1'b0; bus.vl = 5'd3; bus.write_en = 1'b0; #1 outs("s1.T1", 0, 1, 0, 0, 3, 1);
    cyc(); #1 outs("s1.T2", 0, 1, 0, 1, 3, 1);
    cyc(); #1 outs("s1.T3", 0, 1, 0, 2, 1, 1);
    cyc(); #1 outs("s1.T4", 0, 1, 0, 0, 0, 0);
    cyc(); #1 outs("s1.T5", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("s1.T6", 1, 0, 0, 0, 0, 0);

    // vl=0: straight to response
    issue(5'd0, 2'd0, 1'b1);
    cyc(); bus.req = 1'b0; #1 outs("vl0.T1", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("vl0.T2", 1, 0, 0, 0, 0, 0);

    // reserved element width behaves as an empty op
    issue(5'd5, 2'd3, 1'b1);
    cyc(); bus.req = 1'b0; #1 outs("sew3.T1", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("sew3.T2", 1, 0, 0, 0, 0, 0);

    // vl=16, sew=32b clamps to 4 elements, single beat
    issue(5'd16, 2'd2, 1'b1);
    cyc(); bus.req = 1'b0; #1 outs("clamp4.T1", 0, 1, 0, 0, 3, 1);
    cyc(); #1 outs("clamp4.T2", 0, 1, 0, 0, 0, 0);
    cyc(); #1 outs("clamp4.T3", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("clamp4.T4", 1, 0, 0, 0, 0, 0);

    // vl=7, sew=16b without register write: beats of 4,3
    issue(5'd7, 2'd1, 1'b0);
    cyc(); bus.req = 1'b0; #1 outs("vl7.T1", 0, 1, 0, 0, 3, 0);
    cyc(); #1 outs("vl7.T2", 0, 1, 0, 1, 2, 0);
    cyc(); #1 outs("vl7.T3", 0, 1, 0, 0, 0, 0);
    cyc(); #1 outs("vl7.T4", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("vl7.T5", 1, 0, 0, 0, 0, 0);

    // two-cycle stall on beat 1 of a 3-beat op; stall in drain is ignored
    issue(5'd12, 2'd0, 1'b1);
    cyc(); bus.req = 1'b0; #1 outs("stall.T1", 0, 1, 0, 0, 3, 1);
    cyc(); bus.stall = 1'b1; #1 outs("stall.T2", 0, 1, 0, 1, 3, 0);
    cyc(); #1 outs("stall.T3", 0, 1, 0, 1, 3, 0);
    cyc(); bus.stall = 1'b0; #1 outs("stall.T4", 0, 1, 0, 1, 3, 1);
    cyc(); #1 outs("stall.T5", 0, 1, 0, 2, 3, 1);
    cyc(); bus.stall = 1'b1; #1 outs("stall.T6", 0, 1, 0, 0, 0, 0);
    cyc(); bus.stall = 1'b0; #1 outs("stall.T7", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("stall.T8", 1, 0, 0, 0, 0, 0);

    // reset during beat 2 aborts without rvalid; next req accepted at once
    issue(5'd12, 2'd0, 1'b1);
    cyc(); bus.req = 1'b0; #1 outs("rst.T1", 0, 1, 0, 0, 3, 1);
    cyc(); #1 outs("rst.T2", 0, 1, 0, 1, 3, 1);
    cyc(); reset = 1'b1; #1 outs("rst.T3", 0, 1, 0, 2, 3, 1);
    cyc(); reset = 1'b0; #1 outs("rst.T4", 1, 0, 0, 0, 0, 0);
    issue(5'd4, 2'd0, 1'b1);
    cyc(); bus.req = 1'b0; #1 outs("rst.T5", 0, 1, 0, 0, 3, 1);
    cyc(); #1 outs("rst.T6", 0, 1, 0, 0, 0, 0);
    cyc(); #1 outs("rst.T7", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("rst.T8", 1, 0, 0, 0, 0, 0);

    // req held throughout: second accept uses the vl present in the IDLE cycle
    issue(5'd8, 2'd0, 1'b1);
    cyc(); bus.vl = 5'd3; #1 outs("held.T1", 0, 1, 0, 0, 3, 1);
    cyc(); #1 outs("held.T2", 0, 1, 0, 1, 3, 1);
    cyc(); #1 outs("held.T3", 0, 1, 0, 0, 0, 0);
    cyc(); #1 outs("held.T4", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("held.T5", 1, 0, 0, 0, 0, 0);
    cyc(); bus.req = 1'b0; #1 outs("held.T6", 0, 1, 0, 0, 2, 1);
    cyc(); #1 outs("held.T7", 0, 1, 0, 0, 0, 0);
    cyc(); #1 outs("held.T8", 0, 1, 1, 0, 0, 0);
    cyc(); #1 outs("held.T9", 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_issue_sequencer.md
VECTOR_ISSUE_SEQUENCER -- requirements
Module: vector_issue_sequencer

Interface
REQ-001 The block SHALL have parameter: PIPE_DEPTH, 1, number of drain cycles between the last beat and the response (legal 0-3).
REQ-002 The block SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  1  decoder requests a sequenced vector op
- gnt  out  1  request accepted this cycle
- vl  in  5  requested vector length, sampled on accept
- vsew  in  2  element width code (0=8b, 1=16b, 2=32b, 3=reserved), sampled on accept
- write_en  in  1  op writes the vector register file, sampled on accept
- stall  in  1  hold the current beat
- cycle_count  out  2  beat index driven to the arithmetic stage
- elements_to_write  out  2  elements in current beat minus one
- vec_reg_write  out  1  register-file write strobe for current beat
- busy  out  1  op in progress
- rvalid  out  1  one-cycle completion pulse to the CPU side
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL implement states IDLE, RUN, DRAIN, RESP.
REQ-005 gnt SHALL equal (state==IDLE), combinationally; accept = req && gnt.
REQ-006 On accept, the block SHALL register vl, vsew and write_en, and compute eff_vl = min(vl, VLMAX), with VLMAX = 16/8/4 for vsew 0/1/2 and eff_vl = 0 for vsew 3.
REQ-007 Beats SHALL number ceil(eff_vl/4) (0-4). Beat k SHALL carry 4 elements except the final beat, which SHALL carry eff_vl - 4*(beats-1).
REQ-008 On accept with eff_vl=0, the next state SHALL be RESP; otherwise it SHALL be RUN with beat index 0.
REQ-009 In RUN, outputs SHALL be: cycle_count = beat index; elements_to_write = elements in beat minus 1 (2'b11 = 4); vec_reg_write = write_en_q && !stall.
REQ-010 In RUN, when stall=1 the beat index and all outputs other than vec_reg_write SHALL hold; the beat SHALL retire only in a cycle with stall=0.
REQ-011 When the final beat retires, the next state SHALL be DRAIN if PIPE_DEPTH>0 (counter loaded with PIPE_DEPTH-1), else RESP.
REQ-012 DRAIN SHALL decrement its counter each cycle regardless of stall, and SHALL go to RESP after the cycle in which the counter is 0.
REQ-013 RESP SHALL last exactly one cycle with rvalid=1, then go to IDLE.
REQ-014 busy SHALL equal (state!=IDLE).
REQ-015 Outside RUN, cycle_count, elements_to_write and vec_reg_write SHALL be 0.
REQ-016 A req asserted outside IDLE SHALL be ignored (gnt=0). The decoder holds req until it sees gnt.
REQ-017 Changes on vl, vsew and write_en after accept SHALL NOT affect the op in progress.
REQ-018 Accept SHALL be possible in the cycle after RESP (back-to-back ops have 1 idle cycle minimum).

Reset
REQ-019 While reset=1 at a clk edge, state SHALL become IDLE and the registered vl/vsew/write_en, beat index and drain counter SHALL clear to 0.
REQ-020 After reset, the block SHALL drive gnt=1, busy=0, rvalid=0, cycle_count=0, elements_to_write=0, vec_reg_write=0.
REQ-021 Reset asserted mid-op (RUN, DRAIN or RESP) SHALL abort the op with no rvalid pulse.

Verification
REQ-022 Scenario: PIPE_DEPTH=1, accept at T with vl=10, vsew=0, write_en=1, no stall -> T+1/T+2/T+3: cycle_count 0/1/2, elements_to_write 3/3/1, vec_reg_write=1; T+4 DRAIN; rvalid=1 only at T+5; gnt=1 at T+6.
REQ-023 Scenario: accept with vl=0 (or vsew=3) -> rvalid=1 at T+1, vec_reg_write never asserted, busy=1 only at T+1.
REQ-024 Scenario: vl=16, vsew=2 -> clamped to 4, a single beat with cycle_count=0 and elements_to_write=3; vl=7, vsew=1 -> beats 3,2.
REQ-025 Scenario: stall=1 for 2 cycles during beat 1 of a 3-beat op -> cycle_count holds 1 and vec_reg_write=0 during the stall; rvalid is delayed by exactly 2 cycles.
REQ-026 Scenario: reset asserted during RUN beat 2 -> next cycle IDLE, all outputs at reset values, no rvalid; a new req is accepted immediately.
REQ-027 Scenario: req held high through RUN/DRAIN/RESP -> gnt=0 throughout; a second accept occurs only in the IDLE cycle after RESP, using the vl present then.
